note_synth: RTL and testbench
=============================

NOTE_SYNTH -- requirements
Module: note_synth

Interface
REQ-001 SHALL have parameter SUSTAIN_CYC, default 2000, sequencer-note duration in clk cycles (legal 1..65535).
REQ-002 SHALL have port clk  input  1  system clock (10 kHz).
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low; clock clk.
REQ-004 SHALL have port sequencer_on  input  1  1 = sequencer mode, 0 = piano mode.
REQ-005 SHALL have port beat  input  4  current beat index from the measure counter (0-7).
REQ-006 SHALL have port seq_note  input  4  OR of all sequencer-player note outputs (0 = rest, 1-13 = lowC..highC).
REQ-007 SHALL have port piano_note  input  4  live keypad note code (0 = no key).
REQ-008 SHALL have port wave_out  output  1  square-wave audio output.
REQ-009 SHALL have port cur_note  output  4  registered code of the note currently sounding (0 = silent).
REQ-010 SHALL have port active  output  1  high while in PLAY_SEQ or PLAY_PIANO.

Function
REQ-011 SHALL implement FSM states IDLE, PLAY_SEQ, PLAY_PIANO; all outputs SHALL be registered.
REQ-012 SHALL register beat into beat_q every cycle; a new-beat event is beat != beat_q.
REQ-013 SHALL treat note codes 14 and 15 on either note input as 0.
REQ-014 Capture (sequencer_on=1, new-beat event, seq_note in 1..13) SHALL, from any state: go to PLAY_SEQ, load cur_note <= seq_note, load sus_cnt <= SUSTAIN_CYC-1, clear div_cnt, clear wave_out.
REQ-015 A new-beat event with seq_note = 0 SHALL NOT stop a sounding note; sustain continues.
REQ-016 In PLAY_SEQ without capture, sus_cnt SHALL decrement each cycle; when sus_cnt = 0, the next state SHALL be IDLE; the note therefore sounds exactly SUSTAIN_CYC cycles.
REQ-017 Capture on the same cycle as sustain expiry SHALL retrigger (capture wins).
REQ-018 With sequencer_on=0: piano_note in 1..13 SHALL give PLAY_PIANO with cur_note <= piano_note; piano_note = 0 SHALL give IDLE the next cycle; no sustain applies.
REQ-019 In PLAY_PIANO, a change of piano_note to another valid code SHALL update cur_note and clear div_cnt and wave_out.
REQ-020 A change of sequencer_on in either direction SHALL force IDLE the next cycle, regardless of state.
REQ-021 In IDLE: cur_note = 0, wave_out = 0, active = 0, div_cnt = 0.
REQ-022 The half-period HP (clk cycles) for codes 1-13 SHALL be 19, 18, 17, 16, 15, 14, 14, 13, 12, 11, 11, 10, 10.
REQ-023 While playing, div_cnt SHALL count 0..HP-1; at HP-1, wave_out SHALL toggle and div_cnt SHALL return to 0; the first rising edge of wave_out SHALL occur HP cycles after cur_note becomes valid.
REQ-024 sus_cnt SHALL be 16 bits and div_cnt 5 bits; neither counter SHALL wrap.

Reset
REQ-025 While n_rst = 0: state = IDLE, cur_note = 0, wave_out = 0, active = 0, sus_cnt = 0, div_cnt = 0, beat_q = 0.
REQ-026 Reset asserted mid-note SHALL silence the output immediately (asynchronous), with no resume after release.
REQ-027 After reset release, beat = 0 SHALL NOT count as a new-beat event.

Verification (SUSTAIN_CYC = 20)
REQ-028 Sequencer mode, beat 0->1 with seq_note = 10: cur_note = 10 and active = 1 for exactly 20 cycles; wave_out toggles every 11 cycles; then IDLE with wave_out = 0.
REQ-029 Note 1 captured, then beat advances after 8 cycles with seq_note = 0: note 1 continues to a total of 20 cycles; cur_note stays 1.
REQ-030 Note 5 captured, then new beat with seq_note = 13 arriving exactly on the expiry cycle: retrigger; cur_note = 13 for 20 further cycles with HP = 10.
REQ-031 Piano mode, piano_note = 3 held 50 cycles, then 0: cur_note = 3 and toggle period = 17 while held; IDLE one cycle after release.
REQ-032 seq_note = 15 on a new beat: no capture; state remains IDLE.
REQ-033 n_rst pulsed low mid-note: all outputs = 0 at once; after release, no sound until the next capture.

Source files
------------

// File: rtl/note_synth.sv
// note_synth: square-wave note generator fed either by the step sequencer
// (fixed-length notes captured on beat changes) or by the live keypad
// (note sounds only while a key is held). All outputs are registered.
module note_synth #(
   parameter int SUSTAIN_CYC = 2000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       sequencer_on,
   input  logic [3:0] beat,
   input  logic [3:0] seq_note,
   input  logic [3:0] piano_note,
   output logic       wave_out,
   output logic [3:0] cur_note,
   output logic       active
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY_SEQ   = 2'd1,
      PLAY_PIANO = 2'd2
   } state_t;

   // Sustain counter reload: counts SUSTAIN_CYC-1 down to 0, so a captured
   // note is held for exactly SUSTAIN_CYC cycles.
   localparam logic [15:0] SUS_LOAD = 16'(SUSTAIN_CYC - 1);

   // Half-period in clk cycles for note codes 1..13 (lowC..highC at 10 kHz).
   function automatic logic [4:0] half_period(input logic [3:0] code);
      case (code)
         4'd1:    return 5'd19;
         4'd2:    return 5'd18;
         4'd3:    return 5'd17;
         4'd4:    return 5'd16;
         4'd5:    return 5'd15;
         4'd6:    return 5'd14;
         4'd7:    return 5'd14;
         4'd8:    return 5'd13;
         4'd9:    return 5'd12;
         4'd10:   return 5'd11;
         4'd11:   return 5'd11;
         4'd12:   return 5'd10;
         4'd13:   return 5'd10;
         default: return 5'd19;
      endcase
   endfunction

   state_t      r_state;
   logic [3:0]  r_beat_q;
   logic        r_seq_on_q;
   logic [3:0]  r_cur_note;
   logic        r_wave;
   logic        r_active;
   logic [15:0] r_sus_cnt;
   logic [4:0]  r_div_cnt;

   state_t      w_state_nx;
   logic [3:0]  w_cur_nx;
   logic        w_wave_nx;
   logic [15:0] w_sus_nx;
   logic [4:0]  w_div_nx;
   logic [4:0]  w_div_step;
   logic        w_wave_step;

   // Codes 14/15 are not notes; fold them to "rest" before any decision.
   logic [3:0]  w_seq_ok;
   logic [3:0]  w_piano_ok;
   logic        w_new_beat;
   logic        w_mode_chg;
   logic        w_capture;
   logic [4:0]  w_hp_last;

   assign w_seq_ok   = (seq_note   > 4'd13) ? 4'd0 : seq_note;
   assign w_piano_ok = (piano_note > 4'd13) ? 4'd0 : piano_note;
   assign w_new_beat = (beat != r_beat_q);
   assign w_mode_chg = (sequencer_on != r_seq_on_q);
   assign w_capture  = sequencer_on && w_new_beat && (w_seq_ok != 4'd0);
   assign w_hp_last  = half_period(r_cur_note) - 5'd1;

   // Divider advance: toggle the wave and restart at the last count of the
   // half-period; >= keeps the counter from ever running past the limit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_div_step  = r_div_cnt + 5'd1;
      w_wave_step = r_wave;
      if (r_div_cnt >= w_hp_last) begin
         w_div_step  = 5'd0;
         w_wave_step = ~r_wave;
      end
   end

   // Next-state and next-output decode; defaults describe the silent IDLE.
   always_comb begin
      w_state_nx = IDLE;
      w_cur_nx   = 4'd0;
      w_wave_nx  = 1'b0;
      w_sus_nx   = 16'd0;
      w_div_nx   = 5'd0;
      if (w_mode_chg) begin
         // Switching between sequencer and piano always drops to silence.
      end else if (sequencer_on) begin
         if (w_capture) begin
            // Capture beats expiry on the same cycle, so the note retriggers.
            w_state_nx = PLAY_SEQ;
            w_cur_nx   = w_seq_ok;
            w_sus_nx   = SUS_LOAD;
         end else if (r_state == PLAY_SEQ && r_sus_cnt != 16'd0) begin
            w_state_nx = PLAY_SEQ;
            w_cur_nx   = r_cur_note;
            w_sus_nx   = r_sus_cnt - 16'd1;
            w_div_nx   = w_div_step;
            w_wave_nx  = w_wave_step;
         end
      end else if (w_piano_ok != 4'd0) begin
         w_state_nx = PLAY_PIANO;
         w_cur_nx   = w_piano_ok;
         // Same key still held: keep oscillating; a new key restarts phase.
         if (r_state == PLAY_PIANO && w_piano_ok == r_cur_note) begin
            w_div_nx  = w_div_step;
            w_wave_nx = w_wave_step;
         end
      end
   end

   // State and output registers with asynchronous silencing reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= IDLE;
         r_beat_q   <= 4'd0;
         r_seq_on_q <= 1'b0;
         r_cur_note <= 4'd0;
         r_wave     <= 1'b0;
         r_active   <= 1'b0;
         r_sus_cnt  <= 16'd0;
         r_div_cnt  <= 5'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state    <= w_state_nx;
         r_beat_q   <= beat;
         r_seq_on_q <= sequencer_on;
         r_cur_note <= w_cur_nx;
         r_wave     <= w_wave_nx;
         r_active   <= (w_state_nx != IDLE);
         r_sus_cnt  <= w_sus_nx;
         r_div_cnt  <= w_div_nx;
      end
   end

   assign wave_out = r_wave;
   assign cur_note = r_cur_note;
   assign active   = r_active;

endmodule

// File: tb/tb_note_synth.sv
// tb_note_synth: directed bench for note_synth with SUSTAIN_CYC = 20.
// A vector table covers single-cycle decisions; hand-written sequences
// cover sustain length, retrigger, piano hold, and async reset.
module tb_note_synth;

   logic       clk;
   logic       n_rst;
   logic       sequencer_on;
   logic [3:0] beat;
   logic [3:0] seq_note;
   logic [3:0] piano_note;
   logic       wave_out;
   logic [3:0] cur_note;
   logic       active;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       seq_on;
      logic [3:0] beat;
      logic [3:0] seq;
      logic [3:0] piano;
      logic [3:0] exp_cur;
      logic       exp_act;
      logic       exp_wave;
   } vec_t;

   vec_t vecs[15];

   note_synth #(.SUSTAIN_CYC(20)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .sequencer_on (sequencer_on),
      .beat         (beat),
      .seq_note     (seq_note),
      .piano_note   (piano_note),
      .wave_out     (wave_out),
      .cur_note     (cur_note),
      .active       (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Advance one clock and settle just after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cur"},  cur_note, 0);
      check({tag, "_act"},  active,   0);
      check({tag, "_wave"}, wave_out, 0);
   endtask

   // k = cycles since the note was loaded; wave rises after hp cycles.
   task automatic check_note(input string tag, input int k, input int code, input int hp);
      string t;
      t = $sformatf("%s_k%0d", tag, k);
      check({t, "_cur"},  cur_note, code);
      check({t, "_act"},  active,   1);
      check({t, "_wave"}, wave_out, (k / hp) % 2);
   endtask

   initial begin
      // seq_on beat seq piano | cur act wave
      vecs[0]  = '{1'b0, 4'd0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd0, 4'd0,  4'd15, 4'd0,  1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'd0, 4'd0,  4'd5,  4'd5,  1'b1, 1'b0};
      vecs[3]  = '{1'b0, 4'd0, 4'd0,  4'd7,  4'd7,  1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'd0, 4'd0,  4'd14, 4'd0,  1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd0, 4'd0,  4'd13, 4'd13, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 4'd0, 4'd0,  4'd13, 4'd0,  1'b0, 1'b0};
      vecs[7]  = '{1'b1, 4'd0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
      vecs[8]  = '{1'b1, 4'd1, 4'd15, 4'd0,  4'd0,  1'b0, 1'b0};
      vecs[9]  = '{1'b1, 4'd2, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
      vecs[10] = '{1'b1, 4'd3, 4'd14, 4'd0,  4'd0,  1'b0, 1'b0};
      vecs[11] = '{1'b1, 4'd3, 4'd9,  4'd0,  4'd0,  1'b0, 1'b0};
      vecs[12] = '{1'b1, 4'd4, 4'd9,  4'd0,  4'd9,  1'b1, 1'b0};
      vecs[13] = '{1'b0, 4'd4, 4'd9,  4'd0,  4'd0,  1'b0, 1'b0};
      vecs[14] = '{1'b0, 4'd4, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};

      sequencer_on = 1'b0;
      beat         = 4'd0;
      seq_note     = 4'd0;
      piano_note   = 4'd0;
      n_rst        = 1'b1;
      #2 n_rst = 1'b0;
      #1 check_idle("reset");
      step();
      step();
      check_idle("reset_hold");
      @(negedge clk);
      n_rst = 1'b1;
      step();
      check_idle("post_reset");

      // Single-cycle decision table.
      for (int i = 0; i < 15; i++) begin
         sequencer_on = vecs[i].seq_on;
         beat         = vecs[i].beat;
         seq_note     = vecs[i].seq;
         piano_note   = vecs[i].piano;
         step();
         check($sformatf("vec%0d_cur", i),  cur_note, vecs[i].exp_cur);
         check($sformatf("vec%0d_act", i),  active,   vecs[i].exp_act);
         check($sformatf("vec%0d_wave", i), wave_out, vecs[i].exp_wave);
      end

      // Sequencer note 10: 20 cycles, half-period 11, then silent.
      sequencer_on = 1'b1;
      beat         = 4'd0;
      seq_note     = 4'd0;
      step();
      check_idle("A_mode");
      beat     = 4'd1;
      seq_note = 4'd10;
      for (int k = 0; k < 20; k++) begin
         step();
         check_note("A", k, 10, 11);
      end
      step();
      check_idle("A_end");

      // Note 1 keeps sounding through a rest beat arriving 8 cycles in.
      beat     = 4'd2;
      seq_note = 4'd1;
      for (int k = 0; k < 20; k++) begin
         if (k == 8) begin
            beat     = 4'd3;
            seq_note = 4'd0;
         end
         step();
         check_note("B", k, 1, 19);
      end
      step();
      check_idle("B_end");

      // Note 5, then note 13 arrives exactly on the expiry cycle.
      beat     = 4'd4;
      seq_note = 4'd5;
      for (int k = 0; k < 20; k++) begin
         step();
         check_note("C1", k, 5, 15);
      end
      beat     = 4'd5;
      seq_note = 4'd13;
      for (int k = 0; k < 20; k++) begin
         step();
         check_note("C2", k, 13, 10);
      end
      step();
      check_idle("C_end");

      // Piano note 3 held 50 cycles, released to silence next cycle.
      sequencer_on = 1'b0;
      step();
      check_idle("D_mode");
      piano_note = 4'd3;
      for (int k = 0; k < 50; k++) begin
         step();
         check_note("D", k, 3, 17);
      end
      piano_note = 4'd0;
      step();
      check_idle("D_release");

      // Reset mid-note silences at once; nothing sounds until a new capture.
      sequencer_on = 1'b1;
      step();
      check_idle("E_mode");
      beat     = 4'd6;
      seq_note = 4'd12;
      for (int k = 0; k < 12; k++) begin
         step();
         check_note("E", k, 12, 10);
      end
      #2 n_rst = 1'b0;
      #1 check_idle("E_async");
      beat = 4'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_idle($sformatf("E_inrst%0d", k));
      end
      @(negedge clk);
      n_rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check_idle($sformatf("E_after%0d", k));
      end
      beat = 4'd1;
      step();
      check_note("E_recap", 0, 12, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
